// File: rtl/pspin_her_gen_if.sv
// pspin_her_gen_if
//   Bundles the three streams of the HER generator and its statistics.
//   desc_* : DMA write descriptors issued for packet-buffer slots (addr/len/tag, valid/ready)
//   cmpl_* : DMA write completions (tag/len, valid/ready)
//   her_*  : Handler Execution Requests towards PsPIN (addr/size/xfer_size/msgid/eom, valid/ready)
//   *_count_o : delivered-HER, tag-mismatch and length-clamp statistics
//   Modports: slave = the HER generator, master = whatever drives descriptors/completions
//   and consumes HERs.
interface pspin_her_gen_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 20,
  parameter int TAG_WIDTH   = 32,
  parameter int MSGID_WIDTH = 10
) ();

  logic [ADDR_WIDTH-1:0]  desc_addr_i;
  logic [LEN_WIDTH-1:0]   desc_len_i;
  logic [TAG_WIDTH-1:0]   desc_tag_i;
  logic                   desc_valid_i;
  logic                   desc_ready_o;

  logic [TAG_WIDTH-1:0]   cmpl_tag_i;
  logic [LEN_WIDTH-1:0]   cmpl_len_i;
  logic                   cmpl_valid_i;
  logic                   cmpl_ready_o;

  logic [ADDR_WIDTH-1:0]  her_addr_o;
  logic [LEN_WIDTH-1:0]   her_size_o;
  logic [LEN_WIDTH-1:0]   her_xfer_size_o;
  logic [MSGID_WIDTH-1:0] her_msgid_o;
  logic                   her_eom_o;
  logic                   her_valid_o;
  logic                   her_ready_i;

  logic [31:0]            her_count_o;
  logic [31:0]            mismatch_count_o;
  logic [31:0]            clamp_count_o;

  modport slave (
    input  desc_addr_i, desc_len_i, desc_tag_i, desc_valid_i,
    output desc_ready_o,
    input  cmpl_tag_i, cmpl_len_i, cmpl_valid_i,
    output cmpl_ready_o,
    output her_addr_o, her_size_o, her_xfer_size_o, her_msgid_o, her_eom_o, her_valid_o,
    input  her_ready_i,
    output her_count_o, mismatch_count_o, clamp_count_o
  );

  modport master (
    output desc_addr_i, desc_len_i, desc_tag_i, desc_valid_i,
    input  desc_ready_o,
    output cmpl_tag_i, cmpl_len_i, cmpl_valid_i,
    input  cmpl_ready_o,
    input  her_addr_o, her_size_o, her_xfer_size_o, her_msgid_o, her_eom_o, her_valid_o,
    output her_ready_i,
    input  her_count_o, mismatch_count_o, clamp_count_o
  );

endinterface

// File: rtl/pspin_her_gen.sv
// pspin_her_gen
//   Consumer end of the packet-buffer allocator. Every DMA write issued into a slot is
//   recorded in an in-order descriptor FIFO; DMA completions are matched against the FIFO
//   head and each match produces one Handler Execution Request. The HER size is the slot
//   size, so PsPIN's feedback hands the exact slot back to the allocator.
//
//   Ports:
//     clk   clock
//     rstn  synchronous active-low reset (clears FIFO, pending HER, counters)
//     bus   pspin_her_gen_if.slave: desc_* in, cmpl_* in, her_* out, *_count_o out
//
//   Configuration macro: PSPIN_HER_GEN_STATS_EN
//     defined   -> her_count_o / mismatch_count_o / clamp_count_o are live 32-bit counters
//     undefined -> counters absent, the three outputs are tied to 0
module pspin_her_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 20,
  parameter int TAG_WIDTH   = 32,
  parameter int MSGID_WIDTH = 10,
  parameter int DESC_DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  pspin_her_gen_if.slave  bus
);

  localparam int              PTR_W      = $clog2(DESC_DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DESC_DEPTH);

  // ---------------------------------------------------------------------------
  // Descriptor FIFO
  // The head entry must be visible in the same cycle a completion is accepted
  // (the tag compare decides the pop), so storage is read asynchronously.
  // Depth is a power of two, so the pointers simply wrap.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_mem [DESC_DEPTH];
  logic [LEN_WIDTH-1:0]  len_mem  [DESC_DEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem  [DESC_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  logic [ADDR_WIDTH-1:0] head_addr;
  logic [LEN_WIDTH-1:0]  head_len;
  logic [TAG_WIDTH-1:0]  head_tag;

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);

  // Ready comes only from the registered count: a pop in the same cycle does
  // not open a slot until the next cycle.
  assign bus.desc_ready_o = !fifo_full;
  assign push             = bus.desc_valid_i && !fifo_full;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_len  = len_mem[rd_ptr_reg];
  assign head_tag  = tag_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= bus.desc_addr_i;
      len_mem[wr_ptr_reg]  <= bus.desc_len_i;
      tag_mem[wr_ptr_reg]  <= bus.desc_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Completion matching
  // A completion is only taken when there is a head to compare against and the
  // output register can accept a new HER; otherwise it stalls, never drops.
  // A mismatching completion is consumed but leaves the head in place.
  // ---------------------------------------------------------------------------
  logic her_valid_reg;
  logic out_free;
  logic cmpl_fire;
  logic tag_match;
  logic clamp_hit;
  logic [LEN_WIDTH-1:0] xfer_size;

  assign out_free         = !her_valid_reg || bus.her_ready_i;
  assign bus.cmpl_ready_o = !fifo_empty && out_free;
  assign cmpl_fire        = bus.cmpl_valid_i && bus.cmpl_ready_o;
  assign tag_match        = (bus.cmpl_tag_i == head_tag);
  assign pop              = cmpl_fire && tag_match;

  // The DMA may report more bytes than the slot holds; never advertise more
  // than the slot to PsPIN.
  assign clamp_hit = (bus.cmpl_len_i > head_len);
  assign xfer_size = clamp_hit ? head_len : bus.cmpl_len_i;

  // ---------------------------------------------------------------------------
  // HER output register
  // Loaded only on a matching completion; when the register is occupied and
  // not accepted, out_free is low so nothing can overwrite it.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]  her_addr_reg;
  logic [LEN_WIDTH-1:0]   her_size_reg;
  logic [LEN_WIDTH-1:0]   her_xfer_size_reg;
  logic [MSGID_WIDTH-1:0] her_msgid_reg;
  logic                   her_eom_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      her_valid_reg     <= 1'b0;
      her_addr_reg      <= '0;
      her_size_reg      <= '0;
      her_xfer_size_reg <= '0;
      her_msgid_reg     <= '0;
      her_eom_reg       <= 1'b0;
    end else if (out_free) begin
      her_valid_reg <= pop;
      if (pop) begin
        her_addr_reg      <= head_addr;
        her_size_reg      <= head_len;
        her_xfer_size_reg <= xfer_size;
        her_msgid_reg     <= head_tag[MSGID_WIDTH-1:0];
        her_eom_reg       <= head_tag[TAG_WIDTH-1];
      end
    end
  end

  assign bus.her_valid_o     = her_valid_reg;
  assign bus.her_addr_o      = her_addr_reg;
  assign bus.her_size_o      = her_size_reg;
  assign bus.her_xfer_size_o = her_xfer_size_reg;
  assign bus.her_msgid_o     = her_msgid_reg;
  assign bus.her_eom_o       = her_eom_reg;

  // ---------------------------------------------------------------------------
  // Statistics (wrap at 2^32)
  // ---------------------------------------------------------------------------
`ifdef PSPIN_HER_GEN_STATS_EN
  logic [31:0] her_count_reg;
  logic [31:0] mismatch_count_reg;
  logic [31:0] clamp_count_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      her_count_reg      <= '0;
      mismatch_count_reg <= '0;
      clamp_count_reg    <= '0;
    end else begin
      if (her_valid_reg && bus.her_ready_i) begin
        her_count_reg <= her_count_reg + 32'd1;
      end
      if (cmpl_fire && !tag_match) begin
        mismatch_count_reg <= mismatch_count_reg + 32'd1;
      end
      if (pop && clamp_hit) begin
        clamp_count_reg <= clamp_count_reg + 32'd1;
      end
    end
  end

  assign bus.her_count_o      = her_count_reg;
  assign bus.mismatch_count_o = mismatch_count_reg;
  assign bus.clamp_count_o    = clamp_count_reg;
`else
  assign bus.her_count_o      = '0;
  assign bus.mismatch_count_o = '0;
  assign bus.clamp_count_o    = '0;
`endif

endmodule

// File: tb/tb_pspin_her_gen.sv
// tb_pspin_her_gen
//   Directed bench for pspin_her_gen: basic HER generation, FIFO full/ready,
//   tag mismatch with head retention, length clamping, output back-pressure
//   and mid-operation reset. Statistic expectations follow PSPIN_HER_GEN_STATS_EN.
module tb_pspin_her_gen;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

`ifdef PSPIN_HER_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pspin_her_gen_if bus ();

  pspin_her_gen dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] stat(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [31:0] addr, input logic [19:0] len, input logic [31:0] tag);
    bus.desc_addr_i  = addr;
    bus.desc_len_i   = len;
    bus.desc_tag_i   = tag;
    bus.desc_valid_i = 1'b1;
    tick();
    bus.desc_valid_i = 1'b0;
  endtask

  task automatic send_cmpl(input logic [31:0] tag, input logic [19:0] len);
    bus.cmpl_tag_i   = tag;
    bus.cmpl_len_i   = len;
    bus.cmpl_valid_i = 1'b1;
    tick();
    bus.cmpl_valid_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.desc_addr_i  = '0;
    bus.desc_len_i   = '0;
    bus.desc_tag_i   = '0;
    bus.desc_valid_i = 1'b0;
    bus.cmpl_tag_i   = '0;
    bus.cmpl_len_i   = '0;
    bus.cmpl_valid_i = 1'b0;
    bus.her_ready_i  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state
    chk("rst_her_valid", 32'(bus.her_valid_o), 32'd0);
    chk("rst_desc_ready", 32'(bus.desc_ready_o), 32'd1);
    chk("rst_cmpl_ready", 32'(bus.cmpl_ready_o), 32'd0);
    chk("rst_her_addr", bus.her_addr_o, 32'd0);
    chk("rst_her_count", bus.her_count_o, 32'd0);
    $display("txn reset done");

    // 1: single packet
    bus.her_ready_i = 1'b1;
    push_desc(32'h1c10_0000, 20'd1536, 32'h8000_0005);
    bus.cmpl_tag_i = 32'h8000_0005;
    bus.cmpl_len_i = 20'd1000;
    bus.cmpl_valid_i = 1'b1;
    #1;
    chk("t1_cmpl_ready", 32'(bus.cmpl_ready_o), 32'd1);
    tick();
    bus.cmpl_valid_i = 1'b0;
    chk("t1_her_valid", 32'(bus.her_valid_o), 32'd1);
    chk("t1_her_addr", bus.her_addr_o, 32'h1c10_0000);
    chk("t1_her_size", 32'(bus.her_size_o), 32'd1536);
    chk("t1_her_xfer", 32'(bus.her_xfer_size_o), 32'd1000);
    chk("t1_her_msgid", 32'(bus.her_msgid_o), 32'd5);
    chk("t1_her_eom", 32'(bus.her_eom_o), 32'd1);
    tick();
    chk("t1_her_valid_after", 32'(bus.her_valid_o), 32'd0);
    chk("t1_her_count", bus.her_count_o, stat(1));
    $display("txn t1 her addr=%0h xfer=%0d", 32'h1c10_0000, 1000);

    // 2: fill FIFO to 16 entries
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t2_ready_before_16th", 32'(bus.desc_ready_o), 32'd1);
      push_desc(32'h1000 + 32'(i) * 32'd64, 20'd64, 32'(i));
    end
    chk("t2_ready_full", 32'(bus.desc_ready_o), 32'd0);
    chk("t2_cmpl_ready_full", 32'(bus.cmpl_ready_o), 32'd1);
    send_cmpl(32'd0, 20'd64);
    chk("t2_ready_after_pop", 32'(bus.desc_ready_o), 32'd1);
    chk("t2_her_addr0", bus.her_addr_o, 32'h1000);
    chk("t2_her_msgid0", 32'(bus.her_msgid_o), 32'd0);
    chk("t2_her_eom0", 32'(bus.her_eom_o), 32'd0);
    // Drain the remaining 15 back to back
    for (int i = 1; i < 16; i++) begin
      bus.cmpl_tag_i   = 32'(i);
      bus.cmpl_len_i   = 20'd64;
      bus.cmpl_valid_i = 1'b1;
      tick();
      chk("t2_drain_valid", 32'(bus.her_valid_o), 32'd1);
      chk("t2_drain_addr", bus.her_addr_o, 32'h1000 + 32'(i) * 32'd64);
    end
    bus.cmpl_valid_i = 1'b0;
    tick();
    chk("t2_empty_cmpl_ready", 32'(bus.cmpl_ready_o), 32'd0);
    chk("t2_her_count", bus.her_count_o, stat(17));
    $display("txn t2 fifo fill/drain done");

    // 3: tag mismatch keeps head
    push_desc(32'h2000, 20'd128, 32'd7);
    send_cmpl(32'd9, 20'd50);
    chk("t3_no_her", 32'(bus.her_valid_o), 32'd0);
    chk("t3_mismatch", bus.mismatch_count_o, stat(1));
    chk("t3_head_kept", 32'(bus.cmpl_ready_o), 32'd1);
    send_cmpl(32'd7, 20'd50);
    chk("t3_her_valid", 32'(bus.her_valid_o), 32'd1);
    chk("t3_her_addr", bus.her_addr_o, 32'h2000);
    chk("t3_her_msgid", 32'(bus.her_msgid_o), 32'd7);
    chk("t3_her_xfer", 32'(bus.her_xfer_size_o), 32'd50);
    tick();
    $display("txn t3 mismatch then match tag 7");

    // 4: clamp
    push_desc(32'h3000, 20'd64, 32'h8000_0003);
    send_cmpl(32'h8000_0003, 20'd100);
    chk("t4_her_valid", 32'(bus.her_valid_o), 32'd1);
    chk("t4_her_size", 32'(bus.her_size_o), 32'd64);
    chk("t4_her_xfer", 32'(bus.her_xfer_size_o), 32'd64);
    chk("t4_her_msgid", 32'(bus.her_msgid_o), 32'd3);
    chk("t4_clamp", bus.clamp_count_o, stat(1));
    tick();
    chk("t4_her_count", bus.her_count_o, stat(19));
    $display("txn t4 clamp 100->64");

    // 5: back-pressure
    bus.her_ready_i = 1'b0;
    push_desc(32'h4000, 20'd256, 32'h20);
    push_desc(32'h4100, 20'd256, 32'h21);
    push_desc(32'h4200, 20'd256, 32'h22);
    bus.cmpl_tag_i   = 32'h20;
    bus.cmpl_len_i   = 20'd200;
    bus.cmpl_valid_i = 1'b1;
    tick();
    bus.cmpl_tag_i = 32'h21;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_hold_valid", 32'(bus.her_valid_o), 32'd1);
      chk("t5_hold_addr", bus.her_addr_o, 32'h4000);
      chk("t5_hold_xfer", 32'(bus.her_xfer_size_o), 32'd200);
      chk("t5_stall_cmpl", 32'(bus.cmpl_ready_o), 32'd0);
      tick();
    end
    bus.her_ready_i = 1'b1;
    #1;
    chk("t5_release_cmpl_ready", 32'(bus.cmpl_ready_o), 32'd1);
    tick();
    chk("t5_her1_valid", 32'(bus.her_valid_o), 32'd1);
    chk("t5_her1_addr", bus.her_addr_o, 32'h4100);
    bus.cmpl_tag_i = 32'h22;
    tick();
    bus.cmpl_valid_i = 1'b0;
    chk("t5_her2_valid", 32'(bus.her_valid_o), 32'd1);
    chk("t5_her2_addr", bus.her_addr_o, 32'h4200);
    tick();
    chk("t5_done_valid", 32'(bus.her_valid_o), 32'd0);
    chk("t5_her_count", bus.her_count_o, stat(22));
    $display("txn t5 back-pressure release 3 hers");

    // 6: reset mid-operation
    bus.her_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_desc(32'h5000 + 32'(i) * 32'h100, 20'd512, 32'h30 + 32'(i));
    send_cmpl(32'h30, 20'd10);
    chk("t6_pending", 32'(bus.her_valid_o), 32'd1);
    chk("t6_mismatch_pre", bus.mismatch_count_o, stat(1));
    rstn = 1'b0;
    tick();
    chk("t6_her_valid", 32'(bus.her_valid_o), 32'd0);
    chk("t6_desc_ready", 32'(bus.desc_ready_o), 32'd1);
    chk("t6_cmpl_ready", 32'(bus.cmpl_ready_o), 32'd0);
    chk("t6_her_addr", bus.her_addr_o, 32'd0);
    chk("t6_her_count", bus.her_count_o, 32'd0);
    chk("t6_mismatch", bus.mismatch_count_o, 32'd0);
    chk("t6_clamp", bus.clamp_count_o, 32'd0);
    rstn = 1'b1;
    tick();
    chk("t6_post_cmpl_ready", 32'(bus.cmpl_ready_o), 32'd0);
    $display("txn t6 reset mid-operation");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
